// File: rtl/wb_stage.sv
// Write-back stage: registers the mem2wb packet, commits it to the register file,
// serves the decode read ports with bypass, and tracks retired instructions.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic                     in_wb_enable,
  input  logic [$clog2(NREGS)-1:0] in_wb_addr,
  input  logic [XLEN-1:0]          in_wb_data,
  input  logic [XLEN-1:0]          in_wb_pc,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     fwd_valid,
  output logic [$clog2(NREGS)-1:0] fwd_addr,
  output logic [XLEN-1:0]          fwd_data,
  output logic [CNT_W-1:0]         instret,
  output logic [XLEN-1:0]          last_pc
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef struct packed {
    logic            valid;
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } stage_t;

  stage_t          stg_q;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            commit;

  assign commit    = stg_q.valid & ~stall;
  assign fwd_valid = stg_q.valid & stg_q.en & (stg_q.addr != '0);
  assign fwd_addr  = stg_q.addr;
  assign fwd_data  = stg_q.data;

  // Stage register: frozen while stalled so the pending entry commits exactly once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg_q <= '0;
    end else if (!stall) begin
      stg_q.valid <= in_valid;
      stg_q.en    <= in_wb_enable;
      stg_q.addr  <= in_wb_addr;
      stg_q.data  <= in_wb_data;
      stg_q.pc    <= in_wb_pc;
    end
  end

  // Architectural register file; x0 is never written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit && stg_q.en && (stg_q.addr != '0)) begin
      rf_q[stg_q.addr] <= stg_q.data;
    end
  end

  // Retirement bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instret <= '0;
      last_pc <= '0;
    end else if (commit) begin
      instret <= instret + CNT_W'(1);
      last_pc <= stg_q.pc;
    end
  end

  // Read ports: pending write-back value wins over the array, x0 reads zero.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (fwd_valid && (rs1_addr == stg_q.addr)) rs1_data = stg_q.data;
      else                                         rs1_data = rf_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (fwd_valid && (rs2_addr == stg_q.addr)) rs2_data = stg_q.data;
      else                                         rs2_data = rf_q[rs2_addr];
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the architectural state.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        in_valid;
  logic        in_wb_enable;
  logic [4:0]  in_wb_addr;
  logic [31:0] in_wb_data;
  logic [31:0] in_wb_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [63:0] instret;
  logic [31:0] last_pc;

  wb_stage dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .in_valid(in_valid), .in_wb_enable(in_wb_enable), .in_wb_addr(in_wb_addr),
    .in_wb_data(in_wb_data), .in_wb_pc(in_wb_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .instret(instret), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r1, r2;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic [63:0] cnt;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural register contents, the one in-flight
  // instruction waiting to retire, and the retirement counters.
  logic [31:0] m_rf [32];
  bit          p_valid, p_en;
  logic [4:0]  p_addr;
  logic [31:0] p_data, p_pc;
  logic [63:0] m_cnt;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    p_valid = 0; p_en = 0; p_addr = '0; p_data = '0; p_pc = '0;
    m_cnt = '0; m_pc = '0;
  endfunction

  // Applies one clock edge: retire the waiting instruction, then accept the next.
  function automatic void model_edge();
    if (!stall) begin
      if (p_valid) begin
        m_cnt = m_cnt + 64'd1;
        m_pc  = p_pc;
        if (p_en && p_addr != 0) m_rf[p_addr] = p_data;
      end
      p_valid = in_valid; p_en = in_wb_enable; p_addr = in_wb_addr;
      p_data = in_wb_data; p_pc = in_wb_pc;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (p_valid && p_en && p_addr != 0 && p_addr == a) return p_data;
    return m_rf[a];
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.r1  = model_read(rs1_addr);
    e.r2  = model_read(rs2_addr);
    e.fv  = p_valid && p_en && (p_addr != 0);
    e.fa  = p_addr;
    e.fd  = p_data;
    e.cnt = m_cnt;
    e.pc  = m_pc;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input bit v, input bit en, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input bit st, input logic [4:0] r1, input logic [4:0] r2);
    in_valid = v; in_wb_enable = en; in_wb_addr = a; in_wb_data = d; in_wb_pc = pc;
    stall = st; rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic cycle(input bit v, input bit en, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input bit st, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    model_edge();
    #1;
    drive(v, en, a, d, pc, st, r1, r2);
    push_exp();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge.
  task automatic reset_pulse(input bit st, input logic [4:0] r1);
    @(posedge clk);
    model_edge();
    #1;
    drive(0, 0, '0, '0, '0, st, r1, r1);
    #1;
    resetn = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    chk("rst_instret", instret, 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rs1_data", 64'(rs1_data), 64'(e.r1));
        chk("rs2_data", 64'(rs2_data), 64'(e.r2));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.fv));
        chk("fwd_addr", 64'(fwd_addr), 64'(e.fa));
        chk("fwd_data", 64'(fwd_data), 64'(e.fd));
        chk("instret", instret, e.cnt);
        chk("last_pc", 64'(last_pc), 64'(e.pc));
      end
    end
  end

  initial begin
    resetn = 1'b0;
    drive(0, 0, '0, '0, '0, 0, '0, '0);
    model_reset();
    push_exp();
    @(negedge clk);
    #1 resetn = 1'b1;

    // Write then read through bypass, then through the array.
    reset_pulse(0, 5'd0);
    cycle(1, 1, 5'd5, 32'hDEADBEEF, 32'h100, 0, 5'd5, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd5, 5'd0);
    @(negedge clk);
    chk("tp1_bypass", 64'(rs1_data), 64'hDEADBEEF);
    chk("tp1_fwd_addr", 64'(fwd_addr), 64'd5);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd5, 5'd0);
    @(negedge clk);
    chk("tp1_array", 64'(rs1_data), 64'hDEADBEEF);
    chk("tp1_instret", instret, 64'd1);
    chk("tp1_last_pc", 64'(last_pc), 64'h100);

    // x0 write is dropped but still retires.
    reset_pulse(0, 5'd0);
    cycle(1, 1, 5'd0, 32'h12345678, 32'h40, 0, 5'd0, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0);
    @(negedge clk);
    chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("x0_read", 64'(rs1_data), 64'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd0);
    @(negedge clk);
    chk("x0_instret", instret, 64'd1);

    // Stall hold: bypass visible, commit exactly once after release.
    reset_pulse(0, 5'd0);
    cycle(1, 1, 5'd7, 32'hA5A5A5A5, 32'h80, 0, 5'd0, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 5'd7);
    @(negedge clk);
    chk("stall_bypass", 64'(rs2_data), 64'hA5A5A5A5);
    chk("stall_instret", instret, 64'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd7);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 5'd7);
    @(negedge clk);
    chk("stall_commit_once", instret, 64'd1);
    chk("stall_array", 64'(rs2_data), 64'hA5A5A5A5);

    // Back-to-back writes to the same register.
    reset_pulse(0, 5'd0);
    cycle(1, 1, 5'd3, 32'd1, 32'h10, 0, 5'd3, 5'd0);
    cycle(1, 1, 5'd3, 32'd2, 32'h14, 0, 5'd3, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd3, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd3, 5'd0);
    @(negedge clk);
    chk("b2b_read", 64'(rs1_data), 64'd2);
    chk("b2b_instret", instret, 64'd2);

    // Non-writing instruction followed by a bubble carrying wb_enable.
    reset_pulse(0, 5'd0);
    cycle(1, 0, 5'd0, 32'h0, 32'h200, 0, 5'd9, 5'd0);
    cycle(0, 1, 5'd9, 32'hFF, 32'h300, 0, 5'd9, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd9, 5'd0);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd9, 5'd0);
    @(negedge clk);
    chk("mix_instret", instret, 64'd1);
    chk("mix_last_pc", 64'(last_pc), 64'h200);
    chk("mix_rf9", 64'(rs1_data), 64'd0);

    // Reset while an entry is held by stall: it must never commit.
    reset_pulse(0, 5'd0);
    cycle(1, 1, 5'd4, 32'h55, 32'h60, 0, 5'd4, 5'd4);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd4, 5'd4);
    reset_pulse(1, 5'd4);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd4, 5'd4);
    cycle(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd4, 5'd4);
    @(negedge clk);
    chk("rst_rf4", 64'(rs1_data), 64'd0);
    chk("rst_instret_after", instret, 64'd0);

    // Randomized traffic with a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      end else begin
        cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 7)), $urandom, $urandom,
              1'($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the in-order single-issue RV32 pipeline. Sits directly downstream of the memory stage and consumes its mem2wb packet.
- Registers the packet and commits results to the 32-entry architectural register file.
- Serves the decode stage's two read ports with same-cycle write bypass, and exposes the pending write-back value as a forwarding source for execute.
- Keeps the retired-instruction counter and last-retired PC.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, number of architectural registers; x0 hardwired to zero
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- stall  in  1  pipeline hold from hazard unit; freezes stage register, suppresses commit
- in_valid  in  1  mem2wb valid_opcode
- in_wb_enable  in  1  mem2wb wb_enable
- in_wb_addr  in  5  mem2wb destination register
- in_wb_data  in  XLEN  mem2wb write-back data (load data or ALU result)
- in_wb_pc  in  XLEN  mem2wb PC of the instruction
- rs1_addr  in  5  decode read port 1 address
- rs2_addr  in  5  decode read port 2 address
- rs1_data  out  XLEN  read port 1 data, combinational
- rs2_data  out  XLEN  read port 2 data, combinational
- fwd_valid  out  1  stage register holds a pending register write
- fwd_addr  out  5  pending write destination
- fwd_data  out  XLEN  pending write data
- instret  out  CNT_W  count of retired instructions
- last_pc  out  XLEN  PC of most recently retired instruction

Behaviour:
- Reset (resetn=0, async):
  - stage register valid/enable cleared, addr/data/pc = 0
  - all register-file entries = 0
  - instret = 0, last_pc = 0
  - fwd_valid = 0, fwd_addr = 0, fwd_data = 0
  - rs1_data/rs2_data then read 0
- Stage register: at each posedge with stall=0, latches in_* into valid_q, en_q, addr_q, data_q, pc_q. With stall=1, holds all contents.
- Commit condition: commit = valid_q & ~stall.
  - On the posedge where commit=1: instret += 1 and last_pc <= pc_q.
  - If additionally en_q=1 and addr_q!=0: regfile[addr_q] <= data_q.
- Commits exactly once per instruction. A stalled entry commits on the first edge with stall=0, in parallel with latching the next packet.
- Latency:
  - Packet presented in cycle N is latched at edge N→N+1.
  - Visible on fwd_* during cycle N+1.
  - Written to the array at edge N+1→N+2 if not stalled.
- fwd_valid = valid_q & en_q & (addr_q!=0); fwd_addr = addr_q; fwd_data = data_q. These are driven regardless of stall.
- Read ports, evaluated per port:
  - addr==0 → 0
  - else if fwd_valid and addr==addr_q → data_q (bypass, also while stalled)
  - else regfile[addr]
- Writes to x0 are dropped; x0 always reads 0, including via bypass.
- Valid instruction with en_q=0 (store/branch): increments instret and updates last_pc; no register write; fwd_valid=0.
- in_valid=0 bubble: no commit, no count, no write, even if in_wb_enable=1.
- instret wraps modulo 2^CNT_W without a flag.
- Reset mid-stall or mid-commit: the pending entry is discarded and not committed; state returns to reset values immediately.
- Register file has no read-during-write hazard: a same-address read sees the pending value through the bypass.

Test Plan:
- Reset then write: in_valid=1, en=1, addr=5, data=0xDEADBEEF, pc=0x100 for one cycle → next cycle fwd_valid=1, fwd_addr=5; rs1_addr=5 reads 0xDEADBEEF via bypass; cycle after, rs1 still 0xDEADBEEF from array; instret=1, last_pc=0x100.
- x0 write: addr=0, data=0x12345678, en=1, valid=1 → fwd_valid=0; rs1_addr=0 reads 0 always; instret increments to 1.
- Stall hold: latch addr=7/data=0xA5A5A5A5, then assert stall 3 cycles → rs2_addr=7 reads 0xA5A5A5A5 (bypass), regfile[7] unchanged, instret unchanged. Deassert → exactly one commit, instret+1, regfile[7]=0xA5A5A5A5.
- Back-to-back same register: addr=3 data=1, then addr=3 data=2, then bubble → rs1_addr=3 reads 1, then 2, then 2; instret=2.
- Non-writing and bubble mix: valid=1/en=0 pc=0x200, then valid=0/en=1 addr=9 data=0xFF → instret=1, last_pc=0x200, regfile[9]=0.
- Async reset mid-stall: pending addr=4/data=0x55 with stall=1, pulse resetn low between edges → outputs and counters 0 immediately; regfile[4] reads 0 after release.
